q24_8_dot_seq: RTL

Q24_8_DOT_SEQ -- requirements
Module: q24_8_dot_seq

---
 rtl/q24_8_dot_seq_pkg.sv | 15 +
 rtl/q24_8_dot_seq_mult.sv | 25 ++
 rtl/q24_8_dot_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/q24_8_dot_seq_pkg.sv
// Shared types and Q24.8 constants for the sequential dot-product engine.
package q24_8_dot_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int          FRACT_BITS = 8;
  localparam logic [31:0] Q_MAX      = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN      = 32'h8000_0000;

endpackage

// File: rtl/q24_8_dot_seq_mult.sv
// Signed Q24.8 multiply: full 64-bit product, rescaled by FRACT_BITS, with
// a flag when the rescaled value does not fit in 32 signed bits.
module fixed_32_mult
  import q24_8_dot_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o,
  output logic        ovf_o
);

  logic signed [63:0] prod;
  logic [63-FRACT_BITS-31:0] hi;
  logic unused_lsb;

  assign prod = $signed(a_i) * $signed(b_i);
  assign p_o  = prod[FRACT_BITS +: 32];

  // Fits only if every bit above the kept sign bit is a copy of it.
  assign hi    = prod[63:FRACT_BITS+31];
  assign ovf_o = !((&hi) || !(|hi));

  assign unused_lsb = ^prod[FRACT_BITS-1:0];

endmodule

// File: rtl/q24_8_dot_seq.sv
// Sequential Q24.8 dot product: bias + sum(a*b) over a streamed operand
// sequence, one shared multiplier, saturating accumulate, sticky overflow.
module q24_8_dot_seq
  import q24_8_dot_seq_pkg::*;
#(
  parameter int MAX_LEN = 16,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [31:0]   bias,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [31:0]   x_a,
  input  logic [31:0]   x_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   result,
  output logic          busy,
  output logic          ovf
);

  state_e        state_q;
  logic [LW-1:0] len_q, cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, p_q, p_d, result_q, m_p, add_d;
  logic          p_vld_q, ovf_q, x_ready_q, res_valid_q, busy_q;
  logic          m_ovf, accept, add_clamp;
  logic [32:0]   sum33;

  fixed_32_mult u_mult (
    .a_i   (x_a),
    .b_i   (x_b),
    .p_o   (m_p),
    .ovf_o (m_ovf)
  );

  assign accept = x_valid && x_ready_q;
  assign cnt_d  = cnt_q + LW'(1);
  assign p_d    = m_ovf ? ((x_a[31] ^ x_b[31]) ? Q_MIN : Q_MAX) : m_p;

  // 33-bit sum: the two top bits disagree exactly when 32-bit range is exceeded.
  assign sum33     = {acc_q[31], acc_q} + {p_q[31], p_q};
  assign add_clamp = sum33[32] ^ sum33[31];
  assign add_d     = add_clamp ? (sum33[32] ? Q_MIN : Q_MAX) : sum33[31:0];
  assign acc_d     = p_vld_q ? add_d : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      ovf_q       <= 1'b0;
      x_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      p_vld_q <= accept;
      if (accept) begin
        p_q <= p_d;
        if (m_ovf) ovf_q <= 1'b1;
      end
      if (p_vld_q) begin
        acc_q <= add_d;
        if (add_clamp) ovf_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: if (start) begin
          acc_q  <= bias;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
          len_q  <= len;
          busy_q <= 1'b1;
          if (len == '0) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
            result_q    <= bias;
          end else begin
            state_q   <= S_RUN;
            x_ready_q <= 1'b1;
          end
        end
        S_RUN: if (accept) begin
          cnt_q <= cnt_d;
          if (cnt_d == len_q) begin
            state_q   <= S_DRAIN;
            x_ready_q <= 1'b0;
          end
        end
        // The last product lands in acc this cycle; capture it as the result.
        S_DRAIN: begin
          state_q     <= S_DONE;
          res_valid_q <= 1'b1;
          result_q    <= acc_d;
        end
        S_DONE: if (res_ready) begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign x_ready   = x_ready_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule
